// File: rtl/qspi_reg_bridge.sv
// Register-access layer for a QSPI slave: decodes write/read command frames from received
// bytes into a small register file and feeds the transmit stage during read-back periods.
module qspi_reg_bridge #(
    parameter int unsigned NREGS = 8
) (
    input  logic                 clk,
    input  logic                 resetn,
    input  logic                 frame_end,
    input  logic                 rx_valid,
    input  logic [7:0]           rx_data,
    input  logic                 tx_ready,
    output logic [7:0]           tx_data,
    output logic                 tx_en,
    output logic [8*NREGS-1:0]   regs,
    output logic [NREGS-1:0]     wr_pulse,
    output logic                 err
);

    localparam int unsigned AW = (NREGS > 1) ? $clog2(NREGS) : 1;
    localparam logic [7:0] CMD_WR = 8'h02;
    localparam logic [7:0] CMD_RD = 8'h0B;

    typedef enum logic [2:0] {
        StCmd,
        StAddr,
        StWdata,
        StRhold,
        StDiscard,
        StTx
    } state_e;

    state_e              r_state;
    logic                r_is_read;
    logic [AW-1:0]       r_ptr;
    logic [7:0]          r_regs [NREGS];
    logic [NREGS-1:0]    r_wr_pulse;
    logic [7:0]          r_tx_data;
    logic                r_tx_en;
    logic                r_err;

    state_e              w_mid_state;
    logic                w_mid_read;
    logic [AW-1:0]       w_mid_ptr;
    logic [AW-1:0]       w_ptr_inc;
    logic                w_we;
    logic                w_err_set;
    logic                w_addr_ok;

    assign w_ptr_inc = r_ptr + AW'(1);
    assign w_addr_ok = ({1'b0, rx_data} < 9'(NREGS));

    // Effect of a received byte alone; frame_end is applied on top of this result so a
    // byte arriving together with frame_end still belongs to the ending frame.
    always_comb begin
        w_mid_state = r_state;
        w_mid_read  = r_is_read;
        w_mid_ptr   = r_ptr;
        w_we        = 1'b0;
        w_err_set   = 1'b0;
        if (rx_valid) begin
            case (r_state)
                StCmd: begin
                    if (rx_data == CMD_WR || rx_data == CMD_RD) begin
                        w_mid_state = StAddr;
                        w_mid_read  = (rx_data == CMD_RD);
                    end else begin
                        w_mid_state = StDiscard;
                        w_err_set   = 1'b1;
                    end
                end
                StAddr: begin
                    if (w_addr_ok) begin
                        w_mid_ptr   = rx_data[AW-1:0];
                        w_mid_state = r_is_read ? StRhold : StWdata;
                    end else begin
                        w_mid_state = StDiscard;
                        w_err_set   = 1'b1;
                    end
                end
                StWdata: begin
                    w_we      = 1'b1;
                    w_mid_ptr = w_ptr_inc;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_state    <= StCmd;
            r_is_read  <= 1'b0;
            r_ptr      <= '0;
            r_wr_pulse <= '0;
            r_tx_data  <= 8'h00;
            r_tx_en    <= 1'b0;
            r_err      <= 1'b0;
            for (int i = 0; i < NREGS; i++) begin
                r_regs[i] <= 8'h00;
            end
        end else begin
            r_wr_pulse <= w_we ? ({{(NREGS-1){1'b0}}, 1'b1} << r_ptr) : '0;
            if (w_we) begin
                r_regs[r_ptr] <= rx_data;
            end
            r_err     <= r_err | w_err_set;
            r_is_read <= w_mid_read;
            r_ptr     <= w_mid_ptr;
            r_state   <= w_mid_state;
            if (frame_end) begin
                case (w_mid_state)
                    StAddr: begin
                        r_state <= StCmd;
                        r_err   <= 1'b1;
                    end
                    StRhold: begin
                        r_state   <= StTx;
                        r_tx_en   <= 1'b1;
                        r_tx_data <= r_regs[w_mid_ptr];
                    end
                    StTx: begin
                        r_state <= StCmd;
                        r_tx_en <= 1'b0;
                    end
                    default: r_state <= StCmd;
                endcase
            end else if (r_state == StTx && tx_ready) begin
                r_ptr     <= w_ptr_inc;
                r_tx_data <= r_regs[w_ptr_inc];
            end
        end
    end

    for (genvar i = 0; i < NREGS; i++) begin : g_regs
        assign regs[8*i +: 8] = r_regs[i];
    end

    assign tx_data  = r_tx_data;
    assign tx_en    = r_tx_en;
    assign wr_pulse = r_wr_pulse;
    assign err      = r_err;

endmodule

// File: tb/tb_qspi_reg_bridge.sv
// Self-checking bench for qspi_reg_bridge: frame-indexed reference model checked every cycle,
// plus directed literal expectations from the test plan.
module tb_qspi_reg_bridge;

    localparam int N = 8;

    logic            clk = 1'b0;
    logic            resetn = 1'b0;
    logic            frame_end = 1'b0;
    logic            rx_valid = 1'b0;
    logic [7:0]      rx_data = 8'h00;
    logic            tx_ready = 1'b0;
    logic [7:0]      tx_data;
    logic            tx_en;
    logic [8*N-1:0]  regs;
    logic [N-1:0]    wr_pulse;
    logic            err;

    int n_checks = 0;
    int n_fail   = 0;

    qspi_reg_bridge #(.NREGS(N)) u_dut (
        .clk       (clk),
        .resetn    (resetn),
        .frame_end (frame_end),
        .rx_valid  (rx_valid),
        .rx_data   (rx_data),
        .tx_ready  (tx_ready),
        .tx_data   (tx_data),
        .tx_en     (tx_en),
        .regs      (regs),
        .wr_pulse  (wr_pulse),
        .err       (err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: tracks byte position within the frame rather than a state machine.
    logic [7:0]   m_regs [N];
    logic [N-1:0] m_wp;
    logic         m_err;
    logic         m_tx;
    int           m_k;
    int           m_cnt;
    logic [7:0]   m_cmd;
    logic [7:0]   m_addr;

    function automatic logic [8*N-1:0] m_flat();
        logic [8*N-1:0] v;
        for (int i = 0; i < N; i++) v[8*i +: 8] = m_regs[i];
        return v;
    endfunction

    always @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            for (int i = 0; i < N; i++) m_regs[i] = 8'h00;
            m_wp = '0; m_err = 1'b0; m_tx = 1'b0; m_k = 0; m_cnt = 0;
            m_cmd = 8'h00; m_addr = 8'h00;
        end else begin
            m_wp = '0;
            if (m_tx) begin
                if (frame_end) m_tx = 1'b0;
                else if (tx_ready) m_k++;
            end else begin
                if (rx_valid) begin
                    if (m_cnt == 0) begin
                        m_cmd = rx_data;
                        if (rx_data != 8'h02 && rx_data != 8'h0B) m_err = 1'b1;
                    end else if (m_cnt == 1) begin
                        m_addr = rx_data;
                        if ((m_cmd == 8'h02 || m_cmd == 8'h0B) && rx_data >= N) m_err = 1'b1;
                    end else if (m_cmd == 8'h02 && m_addr < N) begin
                        m_regs[(m_addr + m_cnt - 2) % N] = rx_data;
                        m_wp[(m_addr + m_cnt - 2) % N] = 1'b1;
                    end
                    m_cnt++;
                end
                if (frame_end) begin
                    if (m_cnt == 1 && (m_cmd == 8'h02 || m_cmd == 8'h0B)) m_err = 1'b1;
                    if (m_cnt >= 2 && m_cmd == 8'h0B && m_addr < N) begin
                        m_tx = 1'b1;
                        m_k = 0;
                    end
                    m_cnt = 0;
                end
            end
        end
        #1;
        if (resetn) begin
            chk("err", 64'(err), 64'(m_err));
            chk("tx_en", 64'(tx_en), 64'(m_tx));
            chk("wr_pulse", 64'(wr_pulse), 64'(m_wp));
            chk("regs", 64'(regs), 64'(m_flat()));
            if (m_tx) chk("tx_data", 64'(tx_data), 64'(m_regs[(m_addr + m_k) % N]));
        end
    end

    // Inputs applied here hold for the following rising edge.
    task automatic step(input logic fe, input logic rv, input logic [7:0] rd, input logic tr);
        @(negedge clk);
        frame_end = fe;
        rx_valid  = rv;
        rx_data   = rd;
        tx_ready  = tr;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, 8'h00, 1'b0);
    endtask

    task automatic frame(input logic [7:0] b [$]);
        foreach (b[i]) step(1'b0, 1'b1, b[i], 1'b0);
        step(1'b1, 1'b0, 8'h00, 1'b0);
        idle(3);
    endtask

    initial begin
        #3;
        chk("rst_regs", 64'(regs), 64'h0);
        chk("rst_tx_en", 64'(tx_en), 64'h0);
        chk("rst_tx_data", 64'(tx_data), 64'h0);
        chk("rst_err", 64'(err), 64'h0);
        chk("rst_wr_pulse", 64'(wr_pulse), 64'h0);
        idle(2);
        resetn = 1'b1;
        idle(2);

        // Write burst 02 03 AA BB
        step(1'b0, 1'b1, 8'h02, 1'b0);
        step(1'b0, 1'b1, 8'h03, 1'b0);
        step(1'b0, 1'b1, 8'hAA, 1'b0);
        step(1'b0, 1'b1, 8'hBB, 1'b0);
        chk("burst_wp0", 64'(wr_pulse), 64'h08);
        chk("burst_reg3", 64'(regs[31:24]), 64'hAA);
        step(1'b1, 1'b0, 8'h00, 1'b0);
        chk("burst_wp1", 64'(wr_pulse), 64'h10);
        chk("burst_reg4", 64'(regs[39:32]), 64'hBB);
        idle(3);
        chk("burst_err", 64'(err), 64'h0);

        // Wrap on write
        frame('{8'h02, 8'h07, 8'h11, 8'h22});
        chk("wrap_reg7", 64'(regs[63:56]), 64'h11);
        chk("wrap_reg0", 64'(regs[7:0]), 64'h22);

        // Read sequence from reg2
        frame('{8'h02, 8'h02, 8'h5A, 8'hC3});
        step(1'b0, 1'b1, 8'h0B, 1'b0);
        step(1'b0, 1'b1, 8'h02, 1'b0);
        step(1'b1, 1'b0, 8'h00, 1'b0);
        step(1'b0, 1'b0, 8'h00, 1'b0);
        chk("rd_tx_en", 64'(tx_en), 64'h1);
        chk("rd_data0", 64'(tx_data), 64'h5A);
        idle(3);
        step(1'b0, 1'b0, 8'h00, 1'b1);
        step(1'b0, 1'b1, 8'h99, 1'b0);
        chk("rd_data1", 64'(tx_data), 64'hC3);
        step(1'b1, 1'b0, 8'h00, 1'b0);
        step(1'b0, 1'b0, 8'h00, 1'b0);
        chk("rd_end_tx_en", 64'(tx_en), 64'h0);
        idle(3);

        // Read wrapping 7 -> 0 (reg7 = 0x11, reg0 = 0x22)
        frame('{8'h0B, 8'h07, 8'hEE});
        chk("rdw_data0", 64'(tx_data), 64'h11);
        step(1'b0, 1'b0, 8'h00, 1'b1);
        idle(1);
        chk("rdw_data1", 64'(tx_data), 64'h22);
        step(1'b1, 1'b0, 8'h00, 1'b0);
        idle(3);

        // Address byte together with frame_end, then tx_ready together with frame_end
        step(1'b0, 1'b1, 8'h0B, 1'b0);
        step(1'b1, 1'b1, 8'h04, 1'b0);
        step(1'b0, 1'b0, 8'h00, 1'b0);
        chk("sim_tx_en", 64'(tx_en), 64'h1);
        chk("sim_data", 64'(tx_data), 64'hBB);
        chk("sim_err", 64'(err), 64'h0);
        idle(2);
        step(1'b1, 1'b0, 8'h00, 1'b1);
        step(1'b0, 1'b0, 8'h00, 1'b0);
        chk("sim_end_tx_en", 64'(tx_en), 64'h0);
        idle(3);

        // Write with last data byte together with frame_end
        step(1'b0, 1'b1, 8'h02, 1'b0);
        step(1'b0, 1'b1, 8'h01, 1'b0);
        step(1'b1, 1'b1, 8'h3C, 1'b0);
        idle(4);
        chk("wfe_reg1", 64'(regs[15:8]), 64'h3C);

        // Errors, each followed by a valid frame
        frame('{8'h55, 8'h01, 8'h02});
        chk("bad_cmd_err", 64'(err), 64'h1);
        chk("bad_cmd_reg1", 64'(regs[15:8]), 64'h3C);
        frame('{8'h02, 8'h05, 8'h77});
        chk("after_bad_cmd", 64'(regs[47:40]), 64'h77);
        frame('{8'h02, 8'h09, 8'h12, 8'h34});
        frame('{8'h02, 8'h06, 8'h66});
        chk("after_bad_addr", 64'(regs[55:48]), 64'h66);
        frame('{8'h02});
        frame('{8'h0B, 8'h06});
        chk("after_trunc_tx_en", 64'(tx_en), 64'h1);
        chk("after_trunc_data", 64'(tx_data), 64'h66);

        // Reset while transmitting
        @(negedge clk);
        #2 resetn = 1'b0;
        #1;
        chk("arst_tx_en", 64'(tx_en), 64'h0);
        chk("arst_regs", 64'(regs), 64'h0);
        chk("arst_tx_data", 64'(tx_data), 64'h0);
        chk("arst_err", 64'(err), 64'h0);
        idle(3);
        resetn = 1'b1;
        idle(2);
        frame('{8'h02, 8'h00, 8'hA5});
        chk("post_rst_reg0", 64'(regs[7:0]), 64'hA5);
        frame('{8'h0B, 8'h00});
        chk("post_rst_data", 64'(tx_data), 64'hA5);
        step(1'b1, 1'b0, 8'h00, 1'b0);
        idle(3);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/qspi_reg_bridge.md
# qspi_reg_bridge

Byte-level register-access layer between the QSPI slave byte engines and the board logic. It consumes received bytes from the QSPI receive stage and decodes write and read command frames into a small register file. For read commands it feeds the QSPI transmit stage byte by byte during the following chip-select period, and it owns the data-line direction control.

## Interface
Parameters:
- NREGS, default 8: number of 8-bit registers; power of two, 2..128.

Ports (one clock; reset is asynchronous and active-low):
- clk  input  1  system clock; all logic is on its rising edge.
- resetn  input  1  asynchronous active-low reset.
- frame_end  input  1  one-clk pulse when chip select deasserts, already synchronised to clk.
- rx_valid  input  1  one-clk pulse; rx_data holds a new received byte.
- rx_data  input  8  received byte.
- tx_ready  input  1  one-clk pulse; transmit stage has taken tx_data and needs the next byte.
- tx_data  output  8  byte offered to the transmit stage.
- tx_en  output  1  1 = slave drives the QSPI data lines (transmit period).
- regs  output  8*NREGS  register contents; register i occupies bits [8i+7:8i].
- wr_pulse  output  NREGS  bit i is high for one clk in the cycle register i takes a new value.
- err  output  1  sticky protocol-error flag.

## Operation
- Frame = bytes received between two frame_end pulses. Byte 0 is the command: 0x02 = write, 0x0B = read, any other value is invalid. Byte 1 is the start address.
- Write frame: bytes 2.. are written to reg[ptr], where ptr starts at the address and increments after each byte, wrapping modulo NREGS.
- Read frame: carries no data bytes; extra bytes are ignored. When the frame ends, the next chip-select period is a transmit period that sends reg[ptr], reg[ptr+1], … with the same wrap rule.
- States:
  - CMD: expecting byte 0.
  - ADDR: expecting byte 1.
  - WDATA: accepting write data.
  - RHOLD: read command decoded; waiting for frame_end.
  - DISCARD: ignoring bytes until frame_end.
  - TX: transmit period.
- Transitions:
  - CMD + rx 0x02 or 0x0B → ADDR (command type latched).
  - CMD + any other byte → DISCARD; err set.
  - ADDR + rx with addr < NREGS → WDATA (write) or RHOLD (read); ptr = addr.
  - ADDR + rx with addr ≥ NREGS → DISCARD; err set.
  - WDATA + rx → write reg[ptr] and increment ptr.
  - RHOLD + rx → ignored.
  - frame_end from CMD, WDATA or DISCARD → CMD.
  - frame_end from ADDR → CMD; err set (truncated frame).
  - frame_end from RHOLD → TX: tx_en = 1, tx_data = reg[ptr].
  - TX + tx_ready → ptr increments; tx_data = reg[new ptr].
  - TX + frame_end → CMD; tx_en = 0.
  - In TX, rx_valid is ignored.
- Reset: state CMD, all regs 0, ptr 0, tx_data 0x00, tx_en 0, wr_pulse 0, err 0. Reset asserted mid-frame or mid-transmit aborts immediately; tx_en drops asynchronously.
- err is cleared only by reset.

## Timing
- rx_valid in cycle n → reg update and wr_pulse bit both visible in cycle n+1.
- frame_end in cycle n ending a read frame → tx_en and tx_data valid in cycle n+1.
- tx_ready in cycle n → next tx_data valid in cycle n+1. The transmit stage needs it only by its next falling QCK, so QCK must be at least 4 clk periods long.
- Master must leave at least 3 clk periods between deselect and the next select. This lets tx_en and tx_data settle before the first shift.
- rx_valid and frame_end in the same cycle: the byte is processed as part of the ending frame first, then the frame_end transition applies. Example: ADDR + byte + frame_end → RHOLD → TX, with no err.
- tx_ready and frame_end in the same cycle in TX: frame_end wins; the ptr increment is irrelevant.
- Registers are updated only from WDATA; reads never modify regs.

## Test plan
- Write burst: frame 02 03 AA BB → reg3 = 0xAA, then reg4 = 0xBB on consecutive updates; wr_pulse = 0x08, then 0x10; err = 0.
- Wrap on write: NREGS = 8, frame 02 07 11 22 → reg7 = 0x11, reg0 = 0x22.
- Read sequence: with reg2 = 0x5A and reg3 = 0xC3, frame 0B 02 then frame_end → tx_en = 1 and tx_data = 0x5A the next cycle. tx_ready → tx_data = 0xC3. frame_end → tx_en = 0, state CMD.
- Errors: command 0x55 → bytes ignored, err = 1. Frame 02 09 (NREGS = 8) → no write, err = 1. A frame of just 02 → err = 1. After each error, the next valid frame still executes.
- Simultaneous events: last address byte and frame_end in the same cycle of a read frame → TX entered and err stays 0. tx_ready with frame_end → tx_en = 0 next cycle.
- Reset mid-TX: resetn low while in TX → tx_en = 0, regs = 0, tx_data = 0x00, err = 0 immediately; normal operation resumes after release.
